// File: rtl/axi4_reg_slice_if.sv
// AXI4 interface bundle shared by both sides of the register slice.
// Master drives requests and write data; slave drives responses.
interface axi4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic [3:0]              AWCACHE;
    logic [2:0]              AWPROT;
    logic [3:0]              AWQOS;
    logic [3:0]              AWREGION;
    logic                    AWVALID;
    logic                    AWREADY;

    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;

    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    logic [ID_WIDTH-1:0]     ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic [3:0]              ARCACHE;
    logic [2:0]              ARPROT;
    logic [3:0]              ARQOS;
    logic [3:0]              ARREGION;
    logic                    ARVALID;
    logic                    ARREADY;

    logic [ID_WIDTH-1:0]     RID;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWCACHE,
        output AWPROT, AWQOS, AWREGION, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARCACHE,
        output ARPROT, ARQOS, ARREGION, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWCACHE,
        input  AWPROT, AWQOS, AWREGION, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARCACHE,
        input  ARPROT, ARQOS, ARREGION, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi4_reg_slice.sv
// AXI4 register slice: each channel is bypass, forward-registered or
// a two-entry skid buffer, chosen per channel by parameter.

// One valid/ready channel stage. MODE 0 = wires, 1 = forward, 2 = skid.
module axi4_reg_slice_chan #(
    parameter int WIDTH = 1,
    parameter int MODE  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             src_valid_i,
    output logic             src_ready_o,
    input  logic [WIDTH-1:0] src_data_i,
    output logic             snk_valid_o,
    input  logic             snk_ready_i,
    output logic [WIDTH-1:0] snk_data_o
);
    generate
        if (MODE == 0) begin : g_bypass
            assign snk_valid_o = src_valid_i;
            assign snk_data_o  = src_data_i;
            assign src_ready_o = snk_ready_i;
        end else if (MODE == 1) begin : g_fwd
            logic             valid_q;
            logic             valid_d;
            logic [WIDTH-1:0] data_q;
            logic             src_hs;

            // Ready is open whenever the register is empty or drains now.
            assign src_ready_o = !rst_i && (!valid_q || snk_ready_i);
            assign snk_valid_o = !rst_i && valid_q;
            assign snk_data_o  = data_q;
            assign src_hs      = src_valid_i && src_ready_o;

            // A load keeps the register full; otherwise a sink ready drains it.
            always_comb begin
                valid_d = valid_q;
                if (src_hs) begin
                    valid_d = 1'b1;
                end else if (snk_ready_i) begin
                    valid_d = 1'b0;
                end
            end

            // Occupancy flag, cleared by reset.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                end
            end

            // Payload has no reset; it only matters while valid_q is set.
            always_ff @(posedge clk_i) begin
                if (src_hs) begin
                    data_q <= src_data_i;
                end
            end
        end else begin : g_skid
            logic             main_valid_q;
            logic             main_valid_d;
            logic             skid_valid_q;
            logic             skid_valid_d;
            logic [WIDTH-1:0] main_q;
            logic [WIDTH-1:0] skid_q;
            logic             src_hs;
            logic             main_free;
            logic             ld_main_skid;
            logic             ld_main_src;
            logic             ld_skid;

            // Ready depends only on the skid flag, so no path crosses sides.
            assign src_ready_o = !rst_i && !skid_valid_q;
            assign snk_valid_o = !rst_i && main_valid_q;
            assign snk_data_o  = main_q;
            assign src_hs      = src_valid_i && src_ready_o;
            assign main_free   = !main_valid_q || snk_ready_i;

            // Main refills from skid first so older beats leave first.
            always_comb begin
                main_valid_d = main_valid_q;
                skid_valid_d = skid_valid_q;
                ld_main_skid = 1'b0;
                ld_main_src  = 1'b0;
                ld_skid      = 1'b0;
                if (main_free) begin
                    if (skid_valid_q) begin
                        ld_main_skid = 1'b1;
                        main_valid_d = 1'b1;
                        skid_valid_d = 1'b0;
                    end else if (src_hs) begin
                        ld_main_src  = 1'b1;
                        main_valid_d = 1'b1;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end else if (src_hs) begin
                    ld_skid      = 1'b1;
                    skid_valid_d = 1'b1;
                end
            end

            // Occupancy flags, both emptied by reset.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    main_valid_q <= 1'b0;
                    skid_valid_q <= 1'b0;
                end else begin
                    main_valid_q <= main_valid_d;
                    skid_valid_q <= skid_valid_d;
                end
            end

            // Payload registers load only on their selected source.
            always_ff @(posedge clk_i) begin
                if (ld_main_skid) begin
                    main_q <= skid_q;
                end else if (ld_main_src) begin
                    main_q <= src_data_i;
                end
                if (ld_skid) begin
                    skid_q <= src_data_i;
                end
            end
        end
    endgenerate
endmodule

module axi4_reg_slice #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int AW_MODE    = 2,
    parameter int W_MODE     = 2,
    parameter int B_MODE     = 2,
    parameter int AR_MODE    = 2,
    parameter int R_MODE     = 2
) (
    input logic    ACLK,
    input logic    ARESET,
    axi4_if.slave  s,
    axi4_if.master m
);
    localparam int AW_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 4 + 3 + 4 + 4;
    localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int B_W  = ID_WIDTH + 2;
    localparam int AR_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 4 + 3 + 4;
    localparam int R_W  = ID_WIDTH + DATA_WIDTH + 2 + 1;

    logic [AW_W-1:0] aw_src, aw_snk;
    logic [W_W-1:0]  w_src,  w_snk;
    logic [B_W-1:0]  b_src,  b_snk;
    logic [AR_W-1:0] ar_src, ar_snk;
    logic [R_W-1:0]  r_src,  r_snk;

    assign aw_src = {s.AWID, s.AWADDR, s.AWLEN, s.AWSIZE, s.AWBURST,
                     s.AWCACHE, s.AWPROT, s.AWQOS, s.AWREGION};
    assign {m.AWID, m.AWADDR, m.AWLEN, m.AWSIZE, m.AWBURST,
            m.AWCACHE, m.AWPROT, m.AWQOS, m.AWREGION} = aw_snk;

    assign w_src = {s.WDATA, s.WSTRB, s.WLAST};
    assign {m.WDATA, m.WSTRB, m.WLAST} = w_snk;

    assign b_src = {m.BID, m.BRESP};
    assign {s.BID, s.BRESP} = b_snk;

    assign ar_src = {s.ARID, s.ARADDR, s.ARLEN, s.ARSIZE, s.ARBURST,
                     s.ARCACHE, s.ARPROT, s.ARREGION};
    assign {m.ARID, m.ARADDR, m.ARLEN, m.ARSIZE, m.ARBURST,
            m.ARCACHE, m.ARPROT, m.ARREGION} = ar_snk;
    assign m.ARQOS = '0;

    assign r_src = {m.RID, m.RDATA, m.RRESP, m.RLAST};
    assign {s.RID, s.RDATA, s.RRESP, s.RLAST} = r_snk;

    axi4_reg_slice_chan #(.WIDTH(AW_W), .MODE(AW_MODE)) u_aw (
        .clk_i(ACLK), .rst_i(ARESET),
        .src_valid_i(s.AWVALID), .src_ready_o(s.AWREADY), .src_data_i(aw_src),
        .snk_valid_o(m.AWVALID), .snk_ready_i(m.AWREADY), .snk_data_o(aw_snk)
    );

    axi4_reg_slice_chan #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
        .clk_i(ACLK), .rst_i(ARESET),
        .src_valid_i(s.WVALID), .src_ready_o(s.WREADY), .src_data_i(w_src),
        .snk_valid_o(m.WVALID), .snk_ready_i(m.WREADY), .snk_data_o(w_snk)
    );

    axi4_reg_slice_chan #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
        .clk_i(ACLK), .rst_i(ARESET),
        .src_valid_i(m.BVALID), .src_ready_o(m.BREADY), .src_data_i(b_src),
        .snk_valid_o(s.BVALID), .snk_ready_i(s.BREADY), .snk_data_o(b_snk)
    );

    axi4_reg_slice_chan #(.WIDTH(AR_W), .MODE(AR_MODE)) u_ar (
        .clk_i(ACLK), .rst_i(ARESET),
        .src_valid_i(s.ARVALID), .src_ready_o(s.ARREADY), .src_data_i(ar_src),
        .snk_valid_o(m.ARVALID), .snk_ready_i(m.ARREADY), .snk_data_o(ar_snk)
    );

    axi4_reg_slice_chan #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
        .clk_i(ACLK), .rst_i(ARESET),
        .src_valid_i(m.RVALID), .src_ready_o(m.RREADY), .src_data_i(r_src),
        .snk_valid_o(s.RVALID), .snk_ready_i(s.RREADY), .snk_data_o(r_snk)
    );
endmodule

// File: tb/tb_axi4_reg_slice.sv
// Testbench for axi4_reg_slice: AW/B/AR skid buffers, W forward
// register, R bypass, with per-channel scoreboards.
module tb_axi4_reg_slice;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) s_if ();
    axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) m_if ();

    axi4_reg_slice #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4),
        .AW_MODE(2), .W_MODE(1), .B_MODE(2), .AR_MODE(2), .R_MODE(0)
    ) dut (
        .ACLK(clk),
        .ARESET(rst),
        .s(s_if.slave),
        .m(m_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_aw(input int i);
        logic [63:0] pay;
        pay = {$urandom, $urandom};
        {s_if.AWID, s_if.AWADDR, s_if.AWLEN, s_if.AWSIZE, s_if.AWBURST,
         s_if.AWCACHE, s_if.AWPROT, s_if.AWQOS, s_if.AWREGION} = pay;
        s_if.AWID    = 4'(i);
        s_if.AWADDR  = 32'h1000 + 32'(i) * 32'h40;
        s_if.AWVALID = (i < 16);
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs = {s_if.AWREADY, s_if.WREADY, s_if.ARREADY, m_if.BREADY,
               m_if.AWVALID, m_if.WVALID, m_if.ARVALID, s_if.BVALID};
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: rdy/vld %b expected %b", obs, 8'h00);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        obs = {s_if.AWREADY, s_if.WREADY, s_if.ARREADY, m_if.BREADY,
               m_if.AWVALID, m_if.WVALID, m_if.ARVALID, s_if.BVALID};
        n_checks++;
        if (obs !== 8'hF0) begin
            n_fail++;
            $display("FAIL reset_release: rdy/vld %b expected %b", obs, 8'hF0);
        end
    endtask

    task automatic test_aw_stream();
        logic [63:0] exp_q[$];
        int          acc_q[$];
        logic [63:0] obs, exp;
        int          sent, got, cyc, acc;
        logic        prev_rdy, prev_mrdy;
        sent = 0; got = 0; cyc = 0;
        prev_rdy = 1'b1; prev_mrdy = 1'b0;
        @(posedge clk); #1;
        drive_aw(sent);
        m_if.AWREADY = 1'b1;
        while (got < 16 && cyc < 200) begin
            @(negedge clk);
            if (s_if.AWVALID && s_if.AWREADY) begin
                exp_q.push_back({s_if.AWID, s_if.AWADDR, s_if.AWLEN,
                    s_if.AWSIZE, s_if.AWBURST, s_if.AWCACHE, s_if.AWPROT,
                    s_if.AWQOS, s_if.AWREGION});
                acc_q.push_back(cyc);
                sent++;
            end
            if (m_if.AWVALID && m_if.AWREADY) begin
                obs = {m_if.AWID, m_if.AWADDR, m_if.AWLEN, m_if.AWSIZE,
                       m_if.AWBURST, m_if.AWCACHE, m_if.AWPROT,
                       m_if.AWQOS, m_if.AWREGION};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL aw_extra: got %h expected no beat", obs);
                end else begin
                    exp = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    if (obs !== exp) begin
                        n_fail++;
                        $display("FAIL aw_beat%0d: got %h expected %h",
                                 got, obs, exp);
                    end
                    n_checks++;
                    if (cyc <= acc) begin
                        n_fail++;
                        $display("FAIL aw_latency: out cycle %0d expected > %0d",
                                 cyc, acc);
                    end
                end
                got++;
            end
            if (!prev_rdy && prev_mrdy) begin
                n_checks++;
                if (s_if.AWREADY !== 1'b1) begin
                    n_fail++;
                    $display("FAIL aw_ready_recover: got %b expected 1",
                             s_if.AWREADY);
                end
            end
            prev_rdy  = s_if.AWREADY;
            prev_mrdy = m_if.AWREADY;
            @(posedge clk); #1;
            cyc++;
            drive_aw(sent);
            m_if.AWREADY = (cyc % 4 == 0) || (cyc % 4 == 3);
        end
        n_checks++;
        if (got != 16 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL aw_count: got %0d beats expected 16", got);
        end
        s_if.AWVALID = 1'b0;
        m_if.AWREADY = 1'b0;
    endtask

    task automatic test_w_forward();
        logic [72:0] exp_q[$];
        logic [72:0] obs, exp;
        int          sent, got, cyc;
        int          first_src, first_vld, first_out, last_out;
        sent = 0; got = 0; cyc = 0;
        first_src = -1; first_vld = -1; first_out = -1; last_out = -1;
        @(posedge clk); #1;
        m_if.WREADY  = 1'b1;
        s_if.WVALID  = 1'b1;
        s_if.WDATA   = 64'(sent);
        s_if.WSTRB   = 8'($urandom);
        s_if.WLAST   = (sent == 7);
        while (got < 8 && cyc < 100) begin
            @(negedge clk);
            if (m_if.WVALID && first_vld < 0) first_vld = cyc;
            if (s_if.WVALID && s_if.WREADY) begin
                if (first_src < 0) first_src = cyc;
                exp_q.push_back({s_if.WDATA, s_if.WSTRB, s_if.WLAST});
                sent++;
            end
            if (m_if.WVALID && m_if.WREADY) begin
                obs = {m_if.WDATA, m_if.WSTRB, m_if.WLAST};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL w_extra: got %h expected no beat", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        n_fail++;
                        $display("FAIL w_beat%0d: got %h expected %h",
                                 got, obs, exp);
                    end
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            s_if.WVALID = (sent < 8);
            s_if.WDATA  = 64'(sent);
            s_if.WSTRB  = 8'($urandom);
            s_if.WLAST  = (sent == 7);
        end
        n_checks++;
        if (got != 8 || first_vld - first_src != 1) begin
            n_fail++;
            $display("FAIL w_latency: beats %0d rise %0d expected 8 and 1",
                     got, first_vld - first_src);
        end
        n_checks++;
        if (last_out - first_out != 7) begin
            n_fail++;
            $display("FAIL w_gapless: span %0d expected 7",
                     last_out - first_out);
        end
        @(negedge clk);
        n_checks++;
        if (m_if.WVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL w_idle: WVALID %b expected 0", m_if.WVALID);
        end
        m_if.WREADY = 1'b0;
    endtask

    task automatic test_r_bypass();
        @(posedge clk); #1;
        s_if.RREADY = 1'b0;
        m_if.RVALID = 1'b1;
        m_if.RDATA  = 64'hDEADBEEF;
        m_if.RID    = 4'h5;
        m_if.RRESP  = 2'b10;
        m_if.RLAST  = 1'b1;
        #1;
        n_checks++;
        if ({s_if.RVALID, s_if.RDATA, s_if.RID, s_if.RRESP, s_if.RLAST}
            !== {1'b1, 64'hDEADBEEF, 4'h5, 2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL r_pass: got %b %h expected 1 deadbeef",
                     s_if.RVALID, s_if.RDATA);
        end
        n_checks++;
        if (m_if.RREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL r_ready_lo: got %b expected 0", m_if.RREADY);
        end
        s_if.RREADY = 1'b1;
        #1;
        n_checks++;
        if (m_if.RREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL r_ready_hi: got %b expected 1", m_if.RREADY);
        end
        m_if.RVALID = 1'b0;
        #1;
        n_checks++;
        if (s_if.RVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL r_valid_lo: got %b expected 0", s_if.RVALID);
        end
        s_if.RREADY = 1'b0;
    endtask

    task automatic test_ar_skid();
        logic [59:0] exp_q[$];
        logic [59:0] obs, exp;
        logic [63:0] pay;
        int          sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        @(posedge clk); #1;
        m_if.ARREADY = 1'b0;
        pay = {$urandom, $urandom};
        {s_if.ARID, s_if.ARADDR, s_if.ARLEN, s_if.ARSIZE, s_if.ARBURST,
         s_if.ARCACHE, s_if.ARPROT, s_if.ARREGION} = pay[59:0];
        s_if.ARID    = 4'(sent + 1);
        s_if.ARQOS   = 4'hA;
        s_if.ARVALID = 1'b1;
        while (got < 3 && cyc < 100) begin
            @(negedge clk);
            if (cyc == 3) begin
                n_checks++;
                if (s_if.ARREADY !== 1'b0 || sent != 2) begin
                    n_fail++;
                    $display("FAIL ar_full: ARREADY %b accepted %0d expected 0 and 2",
                             s_if.ARREADY, sent);
                end
                n_checks++;
                if (m_if.ARVALID !== 1'b1 || m_if.ARID !== 4'h1
                    || m_if.ARQOS !== 4'h0) begin
                    n_fail++;
                    $display("FAIL ar_hold: vld %b id %h qos %h expected 1 1 0",
                             m_if.ARVALID, m_if.ARID, m_if.ARQOS);
                end
            end
            if (s_if.ARVALID && s_if.ARREADY) begin
                exp_q.push_back({s_if.ARID, s_if.ARADDR, s_if.ARLEN,
                    s_if.ARSIZE, s_if.ARBURST, s_if.ARCACHE, s_if.ARPROT,
                    s_if.ARREGION});
                sent++;
            end
            if (m_if.ARVALID && m_if.ARREADY) begin
                obs = {m_if.ARID, m_if.ARADDR, m_if.ARLEN, m_if.ARSIZE,
                       m_if.ARBURST, m_if.ARCACHE, m_if.ARPROT,
                       m_if.ARREGION};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ar_extra: got %h expected no beat", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp || obs[59:56] !== 4'(got + 1)) begin
                        n_fail++;
                        $display("FAIL ar_beat%0d: got %h expected %h id %0d",
                                 got, obs, exp, got + 1);
                    end
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            pay = {$urandom, $urandom};
            if (!(s_if.ARVALID && sent < 3 && s_if.ARID == 4'(sent + 1))) begin
                {s_if.ARID, s_if.ARADDR, s_if.ARLEN, s_if.ARSIZE,
                 s_if.ARBURST, s_if.ARCACHE, s_if.ARPROT,
                 s_if.ARREGION} = pay[59:0];
                s_if.ARID = 4'(sent + 1);
            end
            s_if.ARVALID = (sent < 3);
            m_if.ARREADY = (cyc >= 5);
        end
        n_checks++;
        if (got != 3) begin
            n_fail++;
            $display("FAIL ar_count: got %0d beats expected 3", got);
        end
        s_if.ARVALID = 1'b0;
        m_if.ARREADY = 1'b0;
    endtask

    task automatic test_b_reset();
        logic [7:0] obs;
        @(posedge clk); #1;
        s_if.BREADY = 1'b0;
        m_if.BVALID = 1'b1;
        m_if.BID    = 4'h3;
        m_if.BRESP  = 2'b01;
        @(posedge clk); #1;
        m_if.BID    = 4'h4;
        m_if.BRESP  = 2'b10;
        @(posedge clk); #1;
        m_if.BVALID = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_if.BVALID, s_if.BID, m_if.BREADY} !== {1'b1, 4'h3, 1'b0}) begin
            n_fail++;
            $display("FAIL b_buffered: vld %b id %h rdy %b expected 1 3 0",
                     s_if.BVALID, s_if.BID, m_if.BREADY);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        obs = {s_if.AWREADY, s_if.WREADY, s_if.ARREADY, m_if.BREADY,
               m_if.AWVALID, m_if.WVALID, m_if.ARVALID, s_if.BVALID};
        n_checks++;
        if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL b_in_reset: rdy/vld %b expected %b", obs, 8'h00);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        s_if.BREADY = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({s_if.BVALID, m_if.BREADY} !== 2'b01) begin
                n_fail++;
                $display("FAIL b_no_stale: vld %b rdy %b expected 0 1",
                         s_if.BVALID, m_if.BREADY);
            end
            @(posedge clk); #1;
        end
        m_if.BVALID = 1'b1;
        m_if.BID    = 4'h9;
        m_if.BRESP  = 2'b01;
        @(posedge clk); #1;
        m_if.BVALID = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_if.BVALID, s_if.BID, s_if.BRESP} !== {1'b1, 4'h9, 2'b01}) begin
            n_fail++;
            $display("FAIL b_restart: vld %b id %h resp %b expected 1 9 01",
                     s_if.BVALID, s_if.BID, s_if.BRESP);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (s_if.BVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL b_no_dup: vld %b expected 0", s_if.BVALID);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_q[$];
        logic [5:0] obs, exp;
        int         sent, got, cyc, first_out, last_out;
        sent = 0; got = 0; cyc = 0; first_out = -1; last_out = -1;
        @(posedge clk); #1;
        s_if.BREADY = 1'b1;
        m_if.BVALID = 1'b1;
        {m_if.BID, m_if.BRESP} = 6'($urandom);
        while (got < 32 && cyc < 200) begin
            @(negedge clk);
            if (m_if.BVALID) begin
                n_checks++;
                if (m_if.BREADY !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready: got %b expected 1", m_if.BREADY);
                end
            end
            if (m_if.BVALID && m_if.BREADY) begin
                exp_q.push_back({m_if.BID, m_if.BRESP});
                sent++;
            end
            if (s_if.BVALID && s_if.BREADY) begin
                obs = {s_if.BID, s_if.BRESP};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: got %h expected no beat", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_beat%0d: got %h expected %h",
                                 got, obs, exp);
                    end
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            m_if.BVALID = (sent < 32);
            {m_if.BID, m_if.BRESP} = 6'($urandom);
        end
        n_checks++;
        if (got != 32 || first_out != 1 || last_out - first_out != 31) begin
            n_fail++;
            $display("FAIL b2b_bubbles: beats %0d first %0d span %0d expected 32 1 31",
                     got, first_out, last_out - first_out);
        end
        m_if.BVALID = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        s_if.AWVALID = 1'b0; s_if.AWID = '0; s_if.AWADDR = '0;
        s_if.AWLEN = '0; s_if.AWSIZE = '0; s_if.AWBURST = '0;
        s_if.AWCACHE = '0; s_if.AWPROT = '0; s_if.AWQOS = '0;
        s_if.AWREGION = '0;
        s_if.WVALID = 1'b0; s_if.WDATA = '0; s_if.WSTRB = '0;
        s_if.WLAST = 1'b0;
        s_if.ARVALID = 1'b0; s_if.ARID = '0; s_if.ARADDR = '0;
        s_if.ARLEN = '0; s_if.ARSIZE = '0; s_if.ARBURST = '0;
        s_if.ARCACHE = '0; s_if.ARPROT = '0; s_if.ARQOS = '0;
        s_if.ARREGION = '0;
        s_if.BREADY = 1'b0;
        s_if.RREADY = 1'b0;
        m_if.AWREADY = 1'b0;
        m_if.WREADY  = 1'b0;
        m_if.ARREADY = 1'b0;
        m_if.BVALID = 1'b0; m_if.BID = '0; m_if.BRESP = '0;
        m_if.RVALID = 1'b0; m_if.RID = '0; m_if.RDATA = '0;
        m_if.RRESP = '0; m_if.RLAST = 1'b0;

        test_reset();
        test_aw_stream();
        test_w_forward();
        test_r_bypass();
        test_ar_skid();
        test_b_reset();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t expected end of test", $time);
        $fatal(1);
    end
endmodule
